multi_key_led_ctrl: RTL and testbench



---
 rtl/multi_key_pkg.sv | 23 ++
 rtl/key_filter_ch.sv | 91 +++++++++
 rtl/multi_key_led_ctrl.sv | 94 +++++++++
 tb/tb_multi_key_led_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_key_pkg.sv
// Shared types and helpers for the multi-key debounce / LED mode controller.
package multi_key_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2
  } led_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } press_state_e;

  // Counter width for a counter running 0..terminal-1, never narrower than 1 bit.
  function automatic int cnt_width(input int terminal);
    int w;
    w = $clog2(terminal);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_filter_ch.sv
// One key channel: 2-flop synchroniser, debounce filter and short/long press FSM.
module key_filter_ch
  import multi_key_pkg::*;
#(
  parameter int DEB_CYCLES     = 1_000_000,
  parameter int LONG_CYCLES    = 50_000_000,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_raw,
  output logic key_state,
  output logic short_flag,
  output logic long_flag
);

  localparam int   DEB_W    = cnt_width(DEB_CYCLES);
  localparam int   HOLD_W   = cnt_width(LONG_CYCLES);
  localparam logic RELEASED = (KEY_ACTIVE_LOW != 0);

  logic              sync_q1;
  logic              sync_q2;
  logic              sample;
  logic [DEB_W-1:0]  deb_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  press_state_e      state;

  // Normalised so that 1 always means pressed.
  assign sample = sync_q2 ^ RELEASED;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_q1 <= RELEASED;
      sync_q2 <= RELEASED;
    end else begin
      sync_q1 <= key_raw;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      deb_cnt   <= '0;
      key_state <= 1'b0;
    end else if (sample == key_state) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
      key_state <= sample;
      deb_cnt   <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // A release is honoured before the long terminal if both land on the same cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      short_flag <= 1'b0;
      long_flag  <= 1'b0;
    end else begin
      short_flag <= 1'b0;
      long_flag  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (key_state) begin
            state    <= ST_PRESSED;
            hold_cnt <= '0;
          end
        end
        ST_PRESSED: begin
          if (!key_state) begin
            short_flag <= 1'b1;
            state      <= ST_IDLE;
          end else if (hold_cnt == HOLD_W'(LONG_CYCLES - 1)) begin
            long_flag <= 1'b1;
            state     <= ST_LONG_HELD;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_LONG_HELD: begin
          if (!key_state) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/multi_key_led_ctrl.sv
// NUM_KEYS debounced keys, each driving one LED through an OFF/ON/BLINK mode register.
module multi_key_led_ctrl
  import multi_key_pkg::*;
#(
  parameter int NUM_KEYS       = 4,
  parameter int DEB_CYCLES     = 1_000_000,
  parameter int LONG_CYCLES    = 50_000_000,
  parameter int BLINK_CYCLES   = 12_500_000,
  parameter int KEY_ACTIVE_LOW = 1,
  parameter int LED_ACTIVE_LOW = 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] led_out,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] short_flag,
  output logic [NUM_KEYS-1:0] long_flag
);

  localparam int   BLINK_W = cnt_width(BLINK_CYCLES);
  localparam logic LED_INV = (LED_ACTIVE_LOW != 0);

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic               blink_wrap;
  logic               blink_phase_nxt;

  // One free-running timer keeps every blinking LED in phase.
  assign blink_wrap      = (blink_cnt == BLINK_W'(BLINK_CYCLES - 1));
  assign blink_phase_nxt = blink_phase ^ blink_wrap;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      blink_cnt   <= blink_wrap ? '0 : blink_cnt + 1'b1;
      blink_phase <= blink_phase_nxt;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    led_mode_e mode;
    led_mode_e mode_nxt;
    logic      lit_nxt;
    logic      led_q;

    key_filter_ch #(
      .DEB_CYCLES    (DEB_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
    ) u_filter (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .key_raw   (key_in[i]),
      .key_state (key_state[i]),
      .short_flag(short_flag[i]),
      .long_flag (long_flag[i])
    );

    always_comb begin
      mode_nxt = mode;
      if (long_flag[i]) begin
        mode_nxt = MODE_BLINK;
      end else if (short_flag[i]) begin
        mode_nxt = (mode == MODE_OFF) ? MODE_ON : MODE_OFF;
      end
    end

    // LED register tracks the mode and phase registers updated on the same edge.
    always_comb begin
      lit_nxt = 1'b0;
      case (mode_nxt)
        MODE_ON:    lit_nxt = 1'b1;
        MODE_BLINK: lit_nxt = blink_phase_nxt;
        default:    lit_nxt = 1'b0;
      endcase
    end

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        mode  <= MODE_OFF;
        led_q <= LED_INV;
      end else begin
        mode  <= mode_nxt;
        led_q <= lit_nxt ^ LED_INV;
      end
    end

    assign led_out[i] = led_q;
  end

endmodule

// File: tb/tb_multi_key_led_ctrl.sv
// Directed bench for multi_key_led_ctrl with short debounce/long/blink timings.
module tb_multi_key_led_ctrl;

  localparam int NK    = 4;
  localparam int DEB   = 4;
  localparam int LONG  = 20;
  localparam int BLINK = 5;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [NK-1:0] key_in  = 4'hF;
  logic [NK-1:0] led_out;
  logic [NK-1:0] key_state;
  logic [NK-1:0] short_flag;
  logic [NK-1:0] long_flag;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int short_cnt[NK] = '{default: 0};
  int long_cnt[NK]  = '{default: 0};
  int s_base[NK]    = '{default: 0};
  int l_base[NK]    = '{default: 0};
  logic [7:0] bounce_pat = 8'b0001_0010;

  multi_key_led_ctrl #(
    .NUM_KEYS      (NK),
    .DEB_CYCLES    (DEB),
    .LONG_CYCLES   (LONG),
    .BLINK_CYCLES  (BLINK),
    .KEY_ACTIVE_LOW(1),
    .LED_ACTIVE_LOW(1)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key_in    (key_in),
    .led_out   (led_out),
    .key_state (key_state),
    .short_flag(short_flag),
    .long_flag (long_flag)
  );

  // Clock / reset bookkeeping
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (sys_rst) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  always @(negedge sys_clk) begin
    for (int i = 0; i < NK; i++) begin
      short_cnt[i] += int'(short_flag[i]);
      long_cnt[i]  += int'(long_flag[i]);
    end
  end

  // Expected active-low LED level of a blinking channel n cycles after reset release
  function automatic logic blink_led(input int n);
    return ((n / BLINK) % 2) == 0;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic snap();
    s_base = short_cnt;
    l_base = long_cnt;
  endtask

  task automatic chk_counts(input string tag, input int ch, input int exp_s, input int exp_l);
    chk({tag, "_short_cnt"}, short_cnt[ch] - s_base[ch], exp_s);
    chk({tag, "_long_cnt"},  long_cnt[ch] - l_base[ch],  exp_l);
  endtask

  // Press held 10 cycles then released; the LED is checked on the flag cycle and the one after.
  task automatic short_press(input int ch, input logic blinking, input logic led_before,
                             input logic led_after);
    key_in[ch] = 1'b0;
    tick(5); chk("ks_pre_rise", key_state[ch], 0);
    tick(1); chk("ks_rise", key_state[ch], 1);
    tick(4); key_in[ch] = 1'b1;
    tick(5); chk("ks_held", key_state[ch], 1);
    tick(1); chk("ks_fall", key_state[ch], 0);
             chk("short_early", short_flag[ch], 0);
    tick(1); chk("short_pulse", short_flag[ch], 1);
             chk("long_none", long_flag[ch], 0);
             chk("led_flag_cycle", led_out[ch], blinking ? blink_led(cyc) : led_before);
    tick(1); chk("short_end", short_flag[ch], 0);
             chk("led_after", led_out[ch], led_after);
  endtask

  initial begin
    // Reset
    tick(3);
    chk("rst_led", led_out, 4'hF);
    chk("rst_key_state", key_state, 4'h0);
    chk("rst_short", short_flag, 4'h0);
    chk("rst_long", long_flag, 4'h0);
    chk("rst_phase", dut.blink_phase, 0);
    sys_rst = 1'b0;
    for (int k = 1; k <= BLINK; k++) begin
      tick(1);
      chk("first_phase", dut.blink_phase, (k == BLINK) ? 1 : 0);
    end

    // Clean short presses on channel 0: OFF -> ON -> OFF
    snap();
    short_press(0, 1'b0, 1'b1, 1'b0);
    short_press(0, 1'b0, 1'b0, 1'b1);
    chk_counts("ch0_short", 0, 2, 0);

    // Bounce rejection on channel 1
    snap();
    for (int i = 0; i < 8; i++) begin
      key_in[1] = bounce_pat[i];
      tick(1);
      chk("bounce_ks", key_state[1], 0);
    end
    key_in[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("bounce_ks_settle", key_state[1], 0);
      chk("bounce_led", led_out[1], 1);
    end
    chk_counts("ch1_bounce", 1, 0, 0);

    // Long press on channel 2 enters blink
    snap();
    key_in[2] = 1'b0;
    tick(6);  chk("long_ks_rise", key_state[2], 1);
    tick(20); chk("long_early", long_flag[2], 0);
    tick(1);  chk("long_pulse", long_flag[2], 1);
              chk("long_no_short", short_flag[2], 0);
    for (int k = 28; k <= 50; k++) begin
      tick(1);
      chk("blink_led", led_out[2], blink_led(cyc));
      if (k == 40) key_in[2] = 1'b1;
    end
    chk("long_ks_fall", key_state[2], 0);
    chk_counts("ch2_long", 2, 0, 1);
    short_press(2, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("off_after_blink", led_out[2], 1);
    end

    // Concurrent presses on channels 0 and 3
    snap();
    key_in[0] = 1'b0;
    key_in[3] = 1'b0;
    tick(6);  chk("conc_ks", key_state, 4'b1001);
    tick(4);  key_in[0] = 1'b1;
    tick(6);  chk("conc_ks_fall0", key_state, 4'b1000);
    tick(1);  chk("conc_short", short_flag, 4'b0001);
              chk("conc_long_none", long_flag, 4'b0000);
    tick(1);  chk("conc_led0_on", led_out[0], 0);
              chk("conc_short_end", short_flag, 4'b0000);
    tick(8);  chk("conc_long_early", long_flag, 4'b0000);
    tick(1);  chk("conc_long", long_flag, 4'b1000);
              chk("conc_short_none", short_flag, 4'b0000);
    tick(1);  chk("conc_led3_blink", led_out[3], blink_led(cyc));
    tick(2);  key_in[3] = 1'b1;
    tick(7);  chk("conc_ks_idle", key_state, 4'b0000);
              chk("conc_led1", led_out[1], 1);
              chk("conc_led2", led_out[2], 1);
    chk_counts("conc_ch0", 0, 1, 0);
    chk_counts("conc_ch1", 1, 0, 0);
    chk_counts("conc_ch2", 2, 0, 0);
    chk_counts("conc_ch3", 3, 0, 1);

    // Reset while channel 0 is blinking and the key is still held
    snap();
    key_in[0] = 1'b0;
    tick(27); chk("rst_mid_long", long_flag[0], 1);
    tick(1);  chk("rst_mid_blink", led_out[0], blink_led(cyc));
    tick(2);
    sys_rst = 1'b1;
    tick(1);
    chk("rst_mid_led", led_out, 4'hF);
    chk("rst_mid_ks", key_state, 4'h0);
    chk("rst_mid_flags", {short_flag, long_flag}, 8'h00);
    sys_rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      chk("rerelease_ks", key_state[0], 0);
      chk("rerelease_led0", led_out[0], 1);
      chk("rerelease_led3", led_out[3], 1);
    end
    tick(1);  chk("redebounce_rise", key_state[0], 1);
              chk("redebounce_led0", led_out[0], 1);
    key_in[0] = 1'b1;
    tick(6);  chk("fresh_fall", key_state[0], 0);
    tick(1);  chk("fresh_short", short_flag[0], 1);
    tick(1);  chk("fresh_led_on", led_out[0], 0);
    chk_counts("rst_ch0", 0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
